io_uart_merge: RTL and testbench
================================

Name: io_uart_merge

Overview:
- N-lane IO write merger and UART transmit buffer for the dual-issue SOC.
- Accepts memory-mapped IO writes from NPORTS issue lanes in the same cycle and queues UART bytes in lane order. Lane 0 is oldest in program order.
- Drains the queue to the UART over a valid/ready handshake.
- Owns the LED register, the halt strobe and per-lane status readback. No simultaneous UART write is ever lost silently.

Parameters:
- NPORTS, 2, number of IO lanes (1..4).
- DEPTH, 16, UART FIFO entries; power of two, at least NPORTS.
- LED_W, 6, LED register width.
- CNT_W, 16, width of the dropped-byte counter.

Ports:
- clk  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- io_wr  in  NPORTS  per-lane IO write strobe
- io_addr  in  32*NPORTS  per-lane byte address; lane k is bits [32k+31:32k]
- io_wdata  in  32*NPORTS  per-lane write data
- io_rdata  out  32*NPORTS  per-lane status readback (combinational)
- uart_data  out  8  byte at the FIFO head
- uart_valid  out  1  FIFO not empty
- uart_ready  in  1  UART accepts the byte this cycle
- leds  out  LED_W  LED register
- halt  out  1  halt strobe, one cycle
- overflow  out  1  sticky drop flag
- drop_count  out  CNT_W  bytes dropped, saturating

Behaviour:
- Decode uses wordaddr = io_addr[15:2], one-hot. Bit 0 = LED, bit 1 = UART data, bit 2 = status, bit 3 = halt. More than one bit set: every matching function acts.
- Reset (RESET high at a clk edge):
  - count, rd_ptr, wr_ptr, leds, overflow and drop_count all go to 0.
  - halt is 0 the cycle after reset.
  - Reset wins over any same-cycle write or pop. FIFO contents are discarded.
- Enqueue:
  - Lanes with io_wr & wordaddr[1] are requesters. Bytes io_wdata[7:0] are written in ascending lane index at wr_ptr, wr_ptr+1, and so on, modulo DEPTH.
  - free = DEPTH - count, using the registered count. A pop in the same cycle does not add space.
  - If requesters > free, the first free requesters in lane order are enqueued and the rest are dropped.
- Drop handling: overflow is set to 1, and drop_count is incremented by the number dropped, saturating at all-ones.
- Dequeue:
  - uart_valid = (count != 0). uart_data = mem[rd_ptr].
  - Pop occurs when uart_valid & uart_ready. rd_ptr advances by 1, wrapping.
  - uart_data is stable while uart_valid is high and uart_ready is low.
- Count update: count_next = count + pushes - pop. Simultaneous push and pop are legal at any fill level, including empty and full.
- Latency: a byte written to an empty FIFO at edge t appears with uart_valid = 1 after edge t, i.e. in cycle t+1. There is no bypass.
- Status word:
  - Bit 9 = busy = (free < NPORTS). This keeps the existing bit-9 "not ready" convention, so firmware polling bit 9 remains correct.
  - Bit 10 = overflow. Bits [31:16] = count, zero-extended. All other bits are 0.
  - io_rdata for lane k shows the status word when wordaddr_k[2] is set, else 0. It is combinational from registered state.
- Overflow clear: writing the status address with wdata[10] = 1 clears overflow and drop_count. A drop in the same cycle wins, so overflow = 1 and drop_count = the number dropped that cycle.
- LED: leds <= io_wdata[LED_W-1:0] of the highest-index lane writing the LED address, so the youngest write wins.
- Halt: halt is a registered OR of io_wr & wordaddr[3] across lanes. It is high for exactly one cycle per halting cycle.

Decomposition:
- Package io_map_pkg holds:
  - Word-address bit indices: IO_LED_BIT = 0, IO_UART_BIT = 1, IO_STAT_BIT = 2, IO_HALT_BIT = 3.
  - Status bit positions: STAT_BUSY = 9, STAT_OVF = 10, STAT_CNT_LSB = 16.
- Sub-module multi_push_fifo (params W, DEPTH, NPUSH) holds the ring buffer and the count/pointer logic with per-cycle push mask and single pop.
- io_uart_merge wraps it with decode, LED, halt, overflow and readback.

Test Plan:
- Lanes 0 and 1 write UART 0x41 and 0x42 in the same cycle, uart_ready = 1 → uart_data is 0x41 then 0x42 on consecutive cycles; drop_count = 0.
- uart_ready = 0, 16 single writes 0x00..0x0F, then both lanes write 0x10/0x11 → both dropped; overflow = 1; drop_count = 2; status from lane 1 = 0x0010_0600.
- 15 bytes queued, uart_ready = 0, both lanes write → lane 0 byte stored, lane 1 byte dropped; count = 16; drop_count = 1.
- FIFO full, uart_ready = 1, one lane writes in the same cycle → byte dropped (no same-cycle credit); count = 15 after the edge. Next cycle the write is accepted and count = 16.
- Lane 0 writes LED 0x15 and lane 1 writes LED 0x2A in the same cycle → leds = 0x2A. Lane 1 writes the halt address → halt high for exactly one cycle.
- RESET asserted with 5 bytes queued and a same-cycle UART write → next cycle uart_valid = 0, count = 0, overflow = 0, leds = 0.

Source files
------------

// File: rtl/io_map_pkg.sv
// IO address map and status-word layout shared by the IO merger and firmware-facing logic.
//   Word-address bits (wordaddr = byte_addr[15:2], one-hot decode):
//     IO_LED_BIT, IO_UART_BIT, IO_STAT_BIT, IO_HALT_BIT
//   Status word bit positions: STAT_BUSY, STAT_OVF, STAT_CNT_LSB (count in [31:16])
package io_map_pkg;

  localparam int unsigned IO_LED_BIT  = 0;
  localparam int unsigned IO_UART_BIT = 1;
  localparam int unsigned IO_STAT_BIT = 2;
  localparam int unsigned IO_HALT_BIT = 3;

  localparam int unsigned STAT_BUSY    = 9;
  localparam int unsigned STAT_OVF     = 10;
  localparam int unsigned STAT_CNT_LSB = 16;

  function automatic logic [31:0] stat_word(input logic busy, input logic ovf,
                                            input logic [15:0] cnt);
    logic [31:0] w;
    w                              = '0;
    w[STAT_BUSY]                   = busy;
    w[STAT_OVF]                    = ovf;
    w[STAT_CNT_LSB +: 16]          = cnt;
    return w;
  endfunction

endpackage

// File: rtl/multi_push_fifo.sv
// Ring-buffer FIFO accepting up to NPUSH pushes and one pop per cycle.
//   clk, rst       : clock, synchronous active-high reset
//   push_req       : per-slot push request, slot 0 is oldest
//   push_data      : per-slot data, slot i is bits [W*i +: W]
//   pop_req        : consumer ready; a pop happens only when not empty
//   head, valid    : entry at rd_ptr, FIFO non-empty
//   count, free    : registered occupancy and DEPTH - count
//   n_drop         : requests rejected this cycle for lack of space
module multi_push_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned NPUSH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPUSH-1:0]         push_req,
  input  logic [NPUSH*W-1:0]       push_data,
  input  logic                     pop_req,
  output logic [W-1:0]             head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   free,
  output logic [$clog2(DEPTH):0]   n_drop
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]    mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count_q, n_push, n_dropped;
  logic [NPUSH-1:0] accept;
  logic [PW-1:0]   slot [NPUSH];
  logic            pop;

  // Space is judged on the registered count only: a same-cycle pop gives no credit.
  assign free  = CW'(DEPTH) - count_q;
  assign count = count_q;
  assign valid = (count_q != '0);
  assign head  = mem[rd_ptr];
  assign pop   = valid & pop_req;
  assign n_drop = n_dropped;

  // Requesters are packed in slot order into consecutive entries until space runs out.
  always_comb begin
    n_push    = '0;
    n_dropped = '0;
    accept    = '0;
    for (int unsigned i = 0; i < NPUSH; i++) begin
      slot[i] = wr_ptr + n_push[PW-1:0];
      if (push_req[i]) begin
        if (n_push < free) begin
          accept[i] = 1'b1;
          n_push    = n_push + CW'(1);
        end else begin
          n_dropped = n_dropped + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NPUSH; i++) begin
        if (accept[i]) mem[slot[i]] <= push_data[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr + n_push[PW-1:0];
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_q + n_push - CW'(pop);
    end
  end

endmodule

// File: rtl/io_uart_merge.sv
// N-lane IO write merger: UART transmit queue, LED register, halt strobe, status readback.
//   clk, RESET          : clock, synchronous active-high reset
//   io_wr/io_addr/io_wdata : per-lane IO write, lane k in [32k +: 32]; lane 0 oldest
//   io_rdata            : per-lane combinational status readback
//   uart_data/valid/ready : FIFO head handshake to the UART
//   leds, halt          : LED register, one-cycle halt strobe
//   overflow, drop_count : sticky drop flag and saturating dropped-byte count
module io_uart_merge
  import io_map_pkg::*;
#(
  parameter int unsigned NPORTS = 2,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned LED_W  = 6,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 RESET,
  input  logic [NPORTS-1:0]    io_wr,
  input  logic [32*NPORTS-1:0] io_addr,
  input  logic [32*NPORTS-1:0] io_wdata,
  output logic [32*NPORTS-1:0] io_rdata,
  output logic [7:0]           uart_data,
  output logic                 uart_valid,
  input  logic                 uart_ready,
  output logic [LED_W-1:0]     leds,
  output logic                 halt,
  output logic                 overflow,
  output logic [CNT_W-1:0]     drop_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [NPORTS-1:0]   led_hit, uart_hit, stat_hit, halt_hit;
  logic [8*NPORTS-1:0] uart_bytes;
  logic                stat_clear;
  logic [CW-1:0]       count, free, n_drop;
  logic [CNT_W-1:0]    drop_base;
  logic [CNT_W:0]      drop_sum;
  logic [31:0]         status;

  always_comb begin
    stat_clear = 1'b0;
    for (int unsigned k = 0; k < NPORTS; k++) begin
      led_hit[k]  = io_wr[k] & io_addr[32*k + 2 + IO_LED_BIT];
      uart_hit[k] = io_wr[k] & io_addr[32*k + 2 + IO_UART_BIT];
      stat_hit[k] = io_wr[k] & io_addr[32*k + 2 + IO_STAT_BIT];
      halt_hit[k] = io_wr[k] & io_addr[32*k + 2 + IO_HALT_BIT];
      uart_bytes[8*k +: 8] = io_wdata[32*k +: 8];
      if (stat_hit[k] && io_wdata[32*k + STAT_OVF]) stat_clear = 1'b1;
    end
  end

  multi_push_fifo #(.W(8), .DEPTH(DEPTH), .NPUSH(NPORTS)) u_fifo (
    .clk       (clk),
    .rst       (RESET),
    .push_req  (uart_hit),
    .push_data (uart_bytes),
    .pop_req   (uart_ready),
    .head      (uart_data),
    .valid     (uart_valid),
    .count     (count),
    .free      (free),
    .n_drop    (n_drop)
  );

  // A same-cycle clear restarts the count from zero, so a simultaneous drop is still recorded.
  always_comb begin
    drop_base = stat_clear ? '0 : drop_count;
    drop_sum  = {1'b0, drop_base} + (CNT_W+1)'(n_drop);
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      overflow   <= 1'b0;
      drop_count <= '0;
      leds       <= '0;
      halt       <= 1'b0;
    end else begin
      halt <= |halt_hit;
      if (n_drop != '0) begin
        overflow   <= 1'b1;
        drop_count <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      end else if (stat_clear) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end
      // Ascending lane order: the youngest LED write is the last assignment and wins.
      for (int unsigned k = 0; k < NPORTS; k++) begin
        if (led_hit[k]) leds <= io_wdata[32*k +: LED_W];
      end
    end
  end

  assign status = stat_word(free < CW'(NPORTS), overflow, 16'(count));

  always_comb begin
    for (int unsigned k = 0; k < NPORTS; k++) begin
      io_rdata[32*k +: 32] = io_addr[32*k + 2 + IO_STAT_BIT] ? status : '0;
    end
  end

endmodule

// File: tb/tb_io_uart_merge.sv
module tb_io_uart_merge;

  localparam int unsigned NP = 2;

  localparam logic [31:0] A_LED  = 32'h0000_0004;
  localparam logic [31:0] A_UART = 32'h0000_0008;
  localparam logic [31:0] A_STAT = 32'h0000_0010;
  localparam logic [31:0] A_HALT = 32'h0000_0020;

  logic             clk = 1'b0;
  logic             RESET;
  logic [NP-1:0]    io_wr;
  logic [32*NP-1:0] io_addr, io_wdata, io_rdata;
  logic [7:0]       uart_data;
  logic             uart_valid, uart_ready;
  logic [5:0]       leds;
  logic             halt, overflow;
  logic [15:0]      drop_count;

  int compared   = 0;
  int mismatched = 0;

  io_uart_merge #(.NPORTS(NP), .DEPTH(16), .LED_W(6), .CNT_W(16)) dut (
    .clk        (clk),
    .RESET      (RESET),
    .io_wr      (io_wr),
    .io_addr    (io_addr),
    .io_wdata   (io_wdata),
    .io_rdata   (io_rdata),
    .uart_data  (uart_data),
    .uart_valid (uart_valid),
    .uart_ready (uart_ready),
    .leds       (leds),
    .halt       (halt),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    io_wr    = '0;
    io_addr  = '0;
    io_wdata = '0;
  endtask

  task automatic lane(input int k, input logic [31:0] addr, input logic [31:0] data);
    io_wr[k]            = 1'b1;
    io_addr[32*k +: 32]  = addr;
    io_wdata[32*k +: 32] = data;
  endtask

  // Peek status through lane k without writing.
  task automatic stat(input int k, input string tag, input logic [31:0] exp);
    idle();
    io_addr[32*k +: 32] = A_STAT;
    #1;
    chk(tag, io_rdata[32*k +: 32], exp);
    idle();
  endtask

  initial begin
    idle();
    uart_ready = 1'b0;
    RESET      = 1'b1;
    tick();
    tick();
    RESET = 1'b0;

    chk("rst_valid", 32'(uart_valid), 32'd0);
    chk("rst_leds", 32'(leds), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_halt", 32'(halt), 32'd0);
    stat(0, "rst_stat", 32'h0000_0000);

    // Two lanes, same cycle: lane order preserved.
    uart_ready = 1'b1;
    lane(0, A_UART, 32'h41);
    lane(1, A_UART, 32'h42);
    tick();
    idle();
    chk("pair_valid", 32'(uart_valid), 32'd1);
    chk("pair_b0", 32'(uart_data), 32'h41);
    tick();
    chk("pair_b1", 32'(uart_data), 32'h42);
    tick();
    chk("pair_empty", 32'(uart_valid), 32'd0);
    chk("pair_drop", 32'(drop_count), 32'd0);

    // Fill to 16, then both lanes overflow.
    uart_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      lane(0, A_UART, 32'(i));
      tick();
    end
    idle();
    stat(0, "full_stat", 32'h0010_0200);
    lane(0, A_UART, 32'h10);
    lane(1, A_UART, 32'h11);
    tick();
    idle();
    chk("ovf2_flag", 32'(overflow), 32'd1);
    chk("ovf2_drop", 32'(drop_count), 32'd2);
    stat(1, "ovf2_stat", 32'h0010_0600);
    chk("ovf2_head", 32'(uart_data), 32'h00);

    // Clear overflow through the status address.
    lane(0, A_STAT, 32'h0000_0400);
    tick();
    idle();
    chk("clr_flag", 32'(overflow), 32'd0);
    chk("clr_drop", 32'(drop_count), 32'd0);

    // Drain 16 in order.
    uart_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_%0d", i), 32'(uart_data), 32'(i));
      tick();
    end
    chk("drain_empty", 32'(uart_valid), 32'd0);
    uart_ready = 1'b0;

    // 15 queued: only lane 0 fits.
    for (int i = 0; i < 15; i++) begin
      lane(0, A_UART, 32'h20 + 32'(i));
      tick();
    end
    idle();
    stat(0, "q15_stat", 32'h000F_0200);
    lane(0, A_UART, 32'h50);
    lane(1, A_UART, 32'h51);
    tick();
    idle();
    chk("part_drop", 32'(drop_count), 32'd1);
    stat(0, "part_stat", 32'h0010_0600);

    // Full with a pop: no same-cycle credit.
    uart_ready = 1'b1;
    lane(0, A_UART, 32'h60);
    tick();
    idle();
    uart_ready = 1'b0;
    chk("nocredit_drop", 32'(drop_count), 32'd2);
    stat(0, "nocredit_stat", 32'h000F_0600);
    chk("nocredit_head", 32'(uart_data), 32'h21);
    lane(0, A_UART, 32'h61);
    tick();
    idle();
    stat(0, "refill_stat", 32'h0010_0600);
    chk("refill_drop", 32'(drop_count), 32'd2);

    // LED: youngest lane wins. Halt: one-cycle strobe.
    lane(0, A_LED, 32'h15);
    lane(1, A_LED, 32'h2A);
    tick();
    idle();
    chk("led_young", 32'(leds), 32'h2A);
    lane(1, A_HALT, 32'h0);
    tick();
    idle();
    chk("halt_hi", 32'(halt), 32'd1);
    tick();
    chk("halt_lo", 32'(halt), 32'd0);

    // Drain 11 to leave 5 queued: 0x2C,0x2D,0x2E,0x50,0x61.
    uart_ready = 1'b1;
    repeat (11) tick();
    uart_ready = 1'b0;
    stat(0, "q5_stat", 32'h0005_0400);
    chk("q5_head", 32'(uart_data), 32'h2C);

    // Reset beats same-cycle UART write and halt.
    RESET = 1'b1;
    lane(0, A_UART, 32'h77);
    lane(1, A_HALT, 32'h0);
    tick();
    RESET = 1'b0;
    idle();
    chk("r2_valid", 32'(uart_valid), 32'd0);
    chk("r2_ovf", 32'(overflow), 32'd0);
    chk("r2_leds", 32'(leds), 32'd0);
    chk("r2_drop", 32'(drop_count), 32'd0);
    chk("r2_halt", 32'(halt), 32'd0);
    stat(1, "r2_stat", 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
